// File: rtl/shared_resource_arbiter_pkg.sv
// Shared types for the shared-resource arbiter: default sizes, the request tag and its one-hot decode.
// Pure declarations, no timing or flow control of its own.
package shared_res_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RES_LAT = 1;
  localparam int MAX_REQ     = 16;
  localparam int TAG_IDX_W   = $clog2(MAX_REQ);

  // Index field is sized for the largest supported client count; narrower builds zero-extend.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [MAX_REQ-1:0] onehot_from_idx(input logic [TAG_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/shared_resource_arbiter_if.sv
// Client and shared-resource signal bundle; master is the arbiter, slave is the clients/resource side.
// Wires only: no latency, flow control is valid/ready on the request side and none on responses.
interface shared_resource_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        stall;
  logic                      global_stall;
  logic                      res_in_valid;
  logic [DATA_W-1:0]         res_in_data;
  logic                      res_out_valid;
  logic [DATA_W-1:0]         res_out_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      proto_err;

  modport master (
    input  req_valid, req_data, res_out_valid, res_out_data,
    output req_ready, stall, global_stall, res_in_valid, res_in_data,
           rsp_valid, rsp_data, proto_err
  );

  modport slave (
    output req_valid, req_data, res_out_valid, res_out_data,
    input  req_ready, stall, global_stall, res_in_valid, res_in_data,
           rsp_valid, rsp_data, proto_err
  );

endinterface

// File: rtl/shared_resource_arbiter_rr_core.sv
// Round-robin pick: first set request scanning from ptr upward with explicit wrap at NUM_REQ.
// Purely combinational (zero latency); a losing requester simply sees no grant.
module rr_arbiter_core #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // One extra bit of headroom so ptr+off never overflows before the wrap compare.
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!grant_vld && req[cand]) begin
        grant_vld       = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Arbitrates NUM_REQ clients onto one fixed-latency resource: issue registered 1 clk after accept, result routed by tag.
// Losers are stalled via req_ready=0; responses are never back-pressured. Optional counters: SHARED_ARB_STATS_EN.
module shared_resource_arbiter
  import shared_res_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RES_LAT = DEF_RES_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  shared_resource_arbiter_if.master bus
`ifdef SHARED_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     grant_cnt,
  output logic [31:0]               conflict_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [NUM_REQ-1:0] stall_vec;
  logic [DATA_W-1:0]  sel_data;
  logic               res_in_valid_q;
  logic [DATA_W-1:0]  res_in_data_q;
  logic               proto_err_q;
  tag_t               tag_pipe [RES_LAT+1];
  tag_t               tag_out;
  logic [NUM_REQ-1:0] rsp_vec;

  rr_arbiter_core #(.NUM_REQ(NUM_REQ)) u_rr_core (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign stall_vec        = bus.req_valid & ~grant;
  assign bus.req_ready    = grant;
  assign bus.stall        = stall_vec;
  assign bus.global_stall = |stall_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr         <= '0;
      res_in_valid_q <= 1'b0;
      res_in_data_q  <= '0;
    end else begin
      res_in_valid_q <= grant_vld;
      if (grant_vld) begin
        rr_ptr        <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        res_in_data_q <= sel_data;
      end
    end
  end

  assign bus.res_in_valid = res_in_valid_q;
  assign bus.res_in_data  = res_in_data_q;

  // Stage 0 mirrors res_in_valid; the RES_LAT stages behind it track the resource's own pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s <= RES_LAT; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: grant_vld, idx: TAG_IDX_W'(grant_idx)};
      for (int s = 1; s <= RES_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign tag_out = tag_pipe[RES_LAT];

  always_comb begin
    rsp_vec = '0;
    if (bus.res_out_valid && tag_out.valid) begin
      rsp_vec = NUM_REQ'(onehot_from_idx(tag_out.idx));
    end
  end

  assign bus.rsp_valid = rsp_vec;
  assign bus.rsp_data  = bus.res_out_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err_q <= 1'b0;
    end else if (bus.res_out_valid != tag_out.valid) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.proto_err = proto_err_q;

`ifdef SHARED_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
        end
      end
      if (($countones(bus.req_valid) >= 2) && (conflict_cnt != 32'hFFFF_FFFF)) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
